// File: rtl/feed_arbiter.sv
// feed_arbiter: packet-atomic round-robin N-to-1 Avalon-ST merge with orphan-beat filtering
// and a registered output stage. Define FEED_ARB_CHAN_ID_EN to add out_channel and grant_overflow.
module feed_arbiter #(
  parameter int C_NUM_CH = 4,
  parameter int C_PKT_DATA_WIDTH = 64,
  localparam int C_PKT_EMPTY_WIDTH = $clog2(C_PKT_DATA_WIDTH / 8),
  localparam int C_CH_ID_WIDTH = $clog2(C_NUM_CH)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [C_NUM_CH-1:0]                     in_valid,
  output logic [C_NUM_CH-1:0]                     in_ready,
  input  logic [C_NUM_CH-1:0]                     in_startofpacket,
  input  logic [C_NUM_CH-1:0]                     in_endofpacket,
  input  logic [C_NUM_CH*C_PKT_DATA_WIDTH-1:0]    in_data,
  input  logic [C_NUM_CH*C_PKT_EMPTY_WIDTH-1:0]   in_empty,
  input  logic [C_NUM_CH-1:0]                     in_error,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_startofpacket,
  output logic                                    out_endofpacket,
  output logic                                    out_error,
  output logic [C_PKT_DATA_WIDTH-1:0]             out_data,
  output logic [C_PKT_EMPTY_WIDTH-1:0]            out_empty,
  output logic [C_NUM_CH-1:0]                     orphan_drop
`ifdef FEED_ARB_CHAN_ID_EN
  ,
  output logic [C_CH_ID_WIDTH-1:0]                out_channel,
  output logic                                    grant_overflow
`endif
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                       state, state_nxt;
  logic [C_CH_ID_WIDTH-1:0]     grant, grant_nxt;
  logic [C_CH_ID_WIDTH-1:0]     last_grant, last_grant_nxt;
  logic [C_CH_ID_WIDTH-1:0]     winner, cand;
  logic                         any_req;
  logic [C_NUM_CH-1:0]          req, orphan;
  logic                         load;
  logic [C_PKT_DATA_WIDTH-1:0]  ch_data  [C_NUM_CH];
  logic [C_PKT_EMPTY_WIDTH-1:0] ch_empty [C_NUM_CH];

  always_comb begin
    for (int i = 0; i < C_NUM_CH; i++) begin
      ch_data[i]  = in_data[i*C_PKT_DATA_WIDTH +: C_PKT_DATA_WIDTH];
      ch_empty[i] = in_empty[i*C_PKT_EMPTY_WIDTH +: C_PKT_EMPTY_WIDTH];
    end
  end

  assign req    = in_valid & in_startofpacket;
  assign orphan = in_valid & ~in_startofpacket;

  // Search begins one past the channel that last completed a packet.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= C_NUM_CH; k++) begin
      cand = C_CH_ID_WIDTH'((int'(last_grant) + k) % C_NUM_CH);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  // Ready is held low throughout reset so nothing is consumed while the block restarts.
  always_comb begin
    in_ready    = '0;
    orphan_drop = '0;
    if (!reset) begin
      if (state == IDLE) begin
        in_ready    = orphan;
        orphan_drop = orphan;
      end else begin
        in_ready[grant] = out_ready | ~out_valid;
      end
    end
  end

  assign load = (state == XFER) && in_valid[grant] && in_ready[grant];

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt = winner;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (load && in_endofpacket[grant]) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= C_CH_ID_WIDTH'(C_NUM_CH - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_error         <= 1'b0;
      out_data          <= '0;
      out_empty         <= '0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_startofpacket <= in_startofpacket[grant];
      out_endofpacket   <= in_endofpacket[grant];
      out_error         <= in_error[grant];
      out_data          <= ch_data[grant];
      out_empty         <= ch_empty[grant];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FEED_ARB_CHAN_ID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_channel    <= '0;
      grant_overflow <= 1'b0;
    end else begin
      if (load)
        out_channel <= grant;
      if (|(in_valid & in_ready & in_error))
        grant_overflow <= 1'b1;
    end
  end
`endif

endmodule
